sm_route_sequencer: RTL
=======================

Name: sm_route_sequencer

Overview:
- Route controller between the node detector and the motor/turn logic of the soil-monitoring bot.
- Watches the detector's node count. On each new node it looks up the programmed action for that position in a small route table.
- Then gates line following, issues turn commands to the motor controller with a valid/ready handshake, waits for turn completion, or holds the bot stationary for a soil-sensing dwell.
- The route table is written through a simple configuration port while the sequencer is idle.

Parameters:
- NODE_W, 6, width of the node count from the detector
- DEPTH, 32, route table entries; addresses 0..DEPTH-1
- SENSE_CYCLES, 5000000, dwell length in clk_50 cycles for SENSE (100 ms at 50 MHz)
- TURN_TIMEOUT, 100000000, maximum cycles in WAIT_TURN before FAULT

Ports:
- clk_50  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins route execution
- cfg_we  in  1  route table write strobe
- cfg_addr  in  5  route table write address
- cfg_data  in  3  action code: 000 STRAIGHT, 001 LEFT, 010 RIGHT, 011 UTURN, 100 SENSE, 101 END, 11x reserved (treated as END)
- nodes  in  NODE_W  node count from the node detector
- cmd_ready  in  1  motor controller accepts the turn command
- turn_done  in  1  pulse from the motor controller when the turn is complete
- run_enable  out  1  line follower enabled
- cmd_valid  out  1  turn command valid
- cmd  out  2  00 LEFT, 01 RIGHT, 10 UTURN
- sense_active  out  1  high during the soil-sensing dwell
- route_idx  out  5  current table index
- busy  out  1  state is not IDLE, DONE or FAULT
- done  out  1  route finished (END reached)
- fault  out  1  sticky; turn timeout or table overrun
- missed  out  1  sticky; a node event occurred outside FOLLOW

Behaviour:
- Reset: all outputs 0, state IDLE, route_idx 0, all counters 0, every table entry = END, nodes_last = 0.
- Node event: `nodes != nodes_last`, evaluated every cycle. nodes_last <= nodes every cycle. An event is seen one cycle after nodes changes.
- Config: a cfg_we write is accepted only in IDLE, DONE or FAULT; writes in any other state are ignored. The write takes effect on the clock edge, so a read in the next cycle returns the new value.
- IDLE:
  - start -> FOLLOW; route_idx <= 0; clear done, fault and missed.
  - start together with cfg_we in the same cycle: both take effect.
- DONE / FAULT:
  - Outputs held. Only start (restart, same as from IDLE) or reset leaves these states.
- FOLLOW:
  - run_enable = 1.
  - On a node event, latch action = table[route_idx] -> DISPATCH.
- DISPATCH (1 cycle, run_enable = 0):
  - STRAIGHT: route_idx += 1 -> FOLLOW.
  - LEFT / RIGHT / UTURN: drive cmd -> CMD.
  - SENSE: clear counter -> SENSE.
  - END: done = 1 -> DONE.
- CMD:
  - cmd_valid = 1; cmd stable until the handshake.
  - cmd_valid & cmd_ready -> WAIT_TURN; cmd_valid drops in the next cycle.
  - No timeout while in CMD.
- WAIT_TURN:
  - run_enable = 0; the counter increments each cycle.
  - turn_done -> route_idx += 1 -> FOLLOW.
  - turn_done in the same cycle the counter reaches TURN_TIMEOUT-1: turn_done wins.
  - Counter reaches TURN_TIMEOUT-1 without turn_done -> FAULT, fault = 1.
- SENSE:
  - sense_active = 1, run_enable = 0, for exactly SENSE_CYCLES cycles.
  - Then route_idx += 1 -> FOLLOW.
- Table overrun: incrementing route_idx past DEPTH-1 -> FAULT, fault = 1. No wrap.
- missed: set on any node event in DISPATCH, CMD, WAIT_TURN or SENSE. The event is otherwise ignored and does not advance route_idx.
- Node events while in IDLE, DONE or FAULT are ignored and do not set missed.
- busy = 1 in FOLLOW, DISPATCH, CMD, WAIT_TURN and SENSE.
- Reset asserted mid-operation returns the block to its reset state immediately. The table contents are reset to END, so the table must be reloaded afterwards.
- Counters are 32-bit unsigned; SENSE_CYCLES and TURN_TIMEOUT must be at least 1.

Test Plan:
- Load table [0]=STRAIGHT, [1]=RIGHT, [2]=END; pulse start; step nodes 0->1->2 (assert cmd_ready, then turn_done 20 cycles later); step nodes 2->3 -> cmd=01 handshake once; route_idx 0,1,2; done=1, busy=0 after the third node.
- Table [0]=SENSE with SENSE_CYCLES=10; one node event -> sense_active high exactly 10 cycles, run_enable low during the dwell, then FOLLOW with route_idx=1.
- Table [0]=LEFT; hold cmd_ready=0 for 50 cycles -> cmd_valid stays 1 and cmd=00 stable, no fault; assert cmd_ready -> cmd_valid drops next cycle.
- TURN_TIMEOUT=100; withhold turn_done -> fault=1, state FAULT after 100 cycles in WAIT_TURN; start -> fault cleared, route_idx=0.
- With SENSE running, increment nodes -> missed=1, route_idx unchanged; a cfg_we write during SENSE does not alter the table (verify by a later read after returning to IDLE).
- All DEPTH=32 entries STRAIGHT; 32 node events -> fault=1 (overrun); then assert rst_n=0 mid-route -> all outputs 0 and the table reads END.

Source files
------------

// File: rtl/sm_route_sequencer.sv
// sm_route_sequencer
// Route controller between the node detector and the motor/turn logic of the
// soil-monitoring bot. Each new node count triggers a lookup of the programmed
// action in a small route table. Depending on that action, the block gates line
// following, issues a turn command, or holds the bot still for a soil-sensing
// dwell.
//
// Ports:
//   clk_50        system clock (50 MHz)
//   rst_n         asynchronous active-low reset (also resets the table to END)
//   start         one-cycle pulse; (re)starts route execution from entry 0
//   cfg_we/addr/data  route table write port, accepted only in IDLE/DONE/FAULT
//   nodes         node count from the detector; any change is a node event
//   cmd_ready     motor controller accepts the turn command
//   turn_done     motor controller finished the turn (pulse)
//   run_enable    line follower enable
//   cmd_valid/cmd turn command (00 LEFT, 01 RIGHT, 10 UTURN)
//   sense_active  soil-sensing dwell in progress
//   route_idx     current table index
//   busy/done     route running / route reached END
//   fault         sticky: turn timeout or table overrun
//   missed        sticky: node event arrived while not following the line
module sm_route_sequencer #(
  parameter int NODE_W       = 6,
  parameter int DEPTH        = 32,
  parameter int SENSE_CYCLES = 5000000,
  parameter int TURN_TIMEOUT = 100000000
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [2:0]        cfg_data,
  input  logic [NODE_W-1:0] nodes,
  input  logic              cmd_ready,
  input  logic              turn_done,
  output logic              run_enable,
  output logic              cmd_valid,
  output logic [1:0]        cmd,
  output logic              sense_active,
  output logic [4:0]        route_idx,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              missed
);

  typedef enum logic [2:0] {
    S_IDLE, S_FOLLOW, S_DISPATCH, S_CMD, S_WAIT_TURN, S_SENSE, S_DONE, S_FAULT
  } state_t;

  localparam logic [2:0]  A_STRAIGHT = 3'b000;
  localparam logic [2:0]  A_LEFT     = 3'b001;
  localparam logic [2:0]  A_RIGHT    = 3'b010;
  localparam logic [2:0]  A_UTURN    = 3'b011;
  localparam logic [2:0]  A_SENSE    = 3'b100;
  localparam logic [2:0]  A_END      = 3'b101;
  localparam logic [4:0]  LAST_IDX   = 5'(DEPTH - 1);
  localparam logic [31:0] SENSE_LAST = 32'(SENSE_CYCLES - 1);
  localparam logic [31:0] TURN_LAST  = 32'(TURN_TIMEOUT - 1);

  state_t            state;
  logic [2:0]        route_tbl [DEPTH];
  logic [2:0]        action;
  logic [31:0]       cnt;
  logic [NODE_W-1:0] nodes_last;
  logic              node_evt;
  logic              cfg_open;
  logic              advance;

  assign node_evt = (nodes != nodes_last);
  assign cfg_open = (state == S_IDLE) || (state == S_DONE) || (state == S_FAULT);

  // Every path that moves on to the next table entry funnels through here so
  // the overrun check lives in one place.
  always_comb begin
    advance = 1'b0;
    if ((state == S_DISPATCH) && (action == A_STRAIGHT)) advance = 1'b1;
    if ((state == S_WAIT_TURN) && turn_done)             advance = 1'b1;
    if ((state == S_SENSE) && (cnt == SENSE_LAST))       advance = 1'b1;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) route_tbl[i] <= A_END;
    end else if (cfg_we && cfg_open) begin
      route_tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      action       <= A_END;
      cnt          <= '0;
      nodes_last   <= '0;
      run_enable   <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd          <= 2'b00;
      sense_active <= 1'b0;
      route_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      missed       <= 1'b0;
    end else begin
      nodes_last <= nodes;

      // Events arriving while the bot is not following the line are lost.
      if (node_evt && ((state == S_DISPATCH) || (state == S_CMD) ||
                       (state == S_WAIT_TURN) || (state == S_SENSE)))
        missed <= 1'b1;

      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            state        <= S_FOLLOW;
            route_idx    <= '0;
            done         <= 1'b0;
            fault        <= 1'b0;
            missed       <= 1'b0;
            busy         <= 1'b1;
            run_enable   <= 1'b1;
            cmd_valid    <= 1'b0;
            sense_active <= 1'b0;
          end
        end
        S_FOLLOW: begin
          if (node_evt) begin
            action     <= route_tbl[route_idx];
            run_enable <= 1'b0;
            state      <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          case (action)
            A_STRAIGHT: ;
            A_LEFT, A_RIGHT, A_UTURN: begin
              // Action codes 1..3 map onto turn commands 0..2.
              cmd       <= action[1:0] - 2'd1;
              cmd_valid <= 1'b1;
              state     <= S_CMD;
            end
            A_SENSE: begin
              cnt          <= '0;
              sense_active <= 1'b1;
              state        <= S_SENSE;
            end
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          endcase
        end
        S_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cnt       <= '0;
            state     <= S_WAIT_TURN;
          end
        end
        S_WAIT_TURN: begin
          // turn_done is handled by advance and takes priority over timeout.
          if (!turn_done) begin
            if (cnt == TURN_LAST) begin
              fault <= 1'b1;
              busy  <= 1'b0;
              state <= S_FAULT;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        S_SENSE: begin
          if (cnt == SENSE_LAST) sense_active <= 1'b0;
          else                   cnt          <= cnt + 32'd1;
        end
        default: state <= S_IDLE;
      endcase

      if (advance) begin
        if (route_idx == LAST_IDX) begin
          fault <= 1'b1;
          busy  <= 1'b0;
          state <= S_FAULT;
        end else begin
          route_idx  <= route_idx + 5'd1;
          run_enable <= 1'b1;
          state      <= S_FOLLOW;
        end
      end
    end
  end

endmodule
